// File: rtl/evt_barrier_merger_if.sv
// Event type definitions and the valid/ready event stream interface shared by the merger.
// The producer drives valid/evt through src; the consumer returns ready through dst.
package sne_evt_pkg;
   typedef enum logic [3:0] {
      EVT_SPIKE = 4'h0,
      EVT_TIME  = 4'h1,
      EVT_SYNCH = 4'h2,
      EVT_OTHER = 4'hF
   } evt_op_e;

   typedef struct packed {
      evt_op_e     operation;
      logic [27:0] payload;
   } evt_synch_t;

   typedef struct packed {
      evt_synch_t synch;
   } sne_evt_t;
endpackage

interface sne_event_stream;
   import sne_evt_pkg::*;
   logic     valid;
   logic     ready;
   sne_evt_t evt;

   modport src (output valid, output evt, input ready);
   modport dst (input valid, input evt, output ready);
endinterface

// File: rtl/evt_barrier_merger.sv
// Merges N event streams: round-robin for normal events, and one coalesced
// time barrier per complete set of barriers on the merge-enabled channels.
module evt_barrier_merger
   import sne_evt_pkg::*;
#(
   parameter int N       = 2,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N-1:0]     merge_en_i,
   input  logic             clear_i,
   sne_event_stream.dst     evt_stream_dst [N-1:0],
   sne_event_stream.src     evt_stream_src,
   output logic [CNT_W-1:0] barrier_cnt_o,
   output logic             align_timeout_o,
   output logic             busy_o
);

   localparam int RR_W   = (N > 1) ? $clog2(N) : 1;
   localparam int ACNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ACNT_W-1:0] TO_VAL = ACNT_W'(TIMEOUT);
   localparam logic [ACNT_W-1:0] TO_M1  = ACNT_W'(TIMEOUT - 1);
   localparam logic [RR_W-1:0]   LAST   = RR_W'(N - 1);

   typedef enum logic {RUN, ALIGN} state_e;

   state_e            state_q;
   logic [ACNT_W-1:0] align_cnt_q;
   logic              timeout_q;
   logic [RR_W-1:0]   rr_q;
   logic [CNT_W-1:0]  bcnt_q;
   logic              out_valid_q;
   sne_evt_t          out_evt_q;

   logic [N-1:0]      in_valid;
   logic [N-1:0]      barrier;
   logic [N-1:0]      held;
   logic [N-1:0]      cand;
   logic [N-1:0]      rdy;
   sne_evt_t          in_evt [N];
   logic              complete;
   logic              load_en;
   logic              gnt_valid;
   logic [RR_W-1:0]   gnt_idx;
   logic [RR_W-1:0]   first_idx;
   logic [RR_W-1:0]   sel_idx;
   sne_evt_t          sel_evt;

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign in_valid[i]             = evt_stream_dst[i].valid;
      assign in_evt[i]               = evt_stream_dst[i].evt;
      assign evt_stream_dst[i].ready = rdy[i];
      assign barrier[i] = in_valid[i] && (in_evt[i].synch.operation == EVT_TIME);
   end

   assign held     = barrier & merge_en_i;
   assign complete = (merge_en_i != '0) && ((barrier & merge_en_i) == merge_en_i);
   assign cand     = in_valid & ~held;
   assign load_en  = ~out_valid_q | evt_stream_src.ready;

   // Round-robin search over non-held channels starting at rr_q, plus the
   // lowest enabled channel whose evt is copied into a coalesced barrier.
   always_comb begin
      int s;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      first_idx = '0;
      s         = 0;
      for (int k = 0; k < N; k++) begin
         s = int'(rr_q) + k;
         if (s >= N) s = s - N;
         if (!gnt_valid && cand[s[RR_W-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = s[RR_W-1:0];
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (merge_en_i[i]) first_idx = RR_W'(i);
      end
   end

   assign sel_idx = complete ? first_idx : gnt_idx;
   assign sel_evt = in_evt[sel_idx];

   always_comb begin
      rdy = '0;
      if (load_en) begin
         if (complete)       rdy = merge_en_i;
         else if (gnt_valid) rdy[gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_evt_q   <= '0;
         rr_q        <= '0;
         bcnt_q      <= '0;
      end else if (load_en) begin
         out_valid_q <= complete | gnt_valid;
         if (complete | gnt_valid) out_evt_q <= sel_evt;
         if (complete) begin
            bcnt_q <= bcnt_q + 1'b1;
         end else if (gnt_valid) begin
            rr_q <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   // Alignment FSM; the timeout flag sets only on the cycle the counter
   // reaches TIMEOUT, so a clear while still saturated in ALIGN sticks.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         align_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (held != '0 && !complete) begin
                  state_q     <= ALIGN;
                  align_cnt_q <= '0;
               end
            end
            ALIGN: begin
               if (align_cnt_q != TO_VAL) align_cnt_q <= align_cnt_q + 1'b1;
               if ((complete && load_en) || held == '0) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
         if (state_q == ALIGN && align_cnt_q == TO_M1) timeout_q <= 1'b1;
         else if (clear_i)                             timeout_q <= 1'b0;
      end
   end

   assign evt_stream_src.valid = out_valid_q;
   assign evt_stream_src.evt   = out_evt_q;
   assign barrier_cnt_o        = bcnt_q;
   assign align_timeout_o      = timeout_q;
   assign busy_o               = out_valid_q | (state_q == ALIGN);

endmodule
